// File: rtl/btb_pkg.sv
// btb_pkg: shared entry layout and counter helper for the 2-way branch target buffer
package btb_pkg;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam int TAG_MW = 28;
    localparam int CNT_MW = 3;
    // Fields are sized for the widest legal configuration; narrower builds zero-extend.
    typedef struct packed {
        logic              valid;
        logic [TAG_MW-1:0] tag;
        logic [31:0]       target;
        logic [CNT_MW-1:0] cnt;
    } btb_entry_t;
    function automatic logic [CNT_MW-1:0] sat_update(input logic [CNT_MW-1:0] cnt, input logic taken, input int cnt_w);
        logic [CNT_MW-1:0] top;
        top = CNT_MW'((1 << cnt_w) - 1);
        return taken ? ((cnt == top) ? cnt : cnt + 1'b1) : ((cnt == '0) ? cnt : cnt - 1'b1);
    endfunction
endpackage

// File: rtl/btb_set_ram.sv
// btb_set_ram: one way of the BTB, async reads for IF and EX, sync write, async clear of valid/cnt
module btb_set_ram import btb_pkg::*; #(
    parameter int SET_ADDR_LEN = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SET_ADDR_LEN-1:0] rd_if_idx_i,
    input  logic [SET_ADDR_LEN-1:0] rd_ex_idx_i,
    input  logic                    wr_en_i,
    input  logic [SET_ADDR_LEN-1:0] wr_idx_i,
    input  btb_entry_t              wr_entry_i,
    output btb_entry_t              rd_if_o,
    output btb_entry_t              rd_ex_o
);
    localparam int SETS = 1 << SET_ADDR_LEN;
    logic [SETS-1:0]   valid_q;
    logic [CNT_MW-1:0] cnt_q    [SETS];
    logic [TAG_MW-1:0] tag_q    [SETS];
    logic [31:0]       target_q [SETS];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < SETS; i++) cnt_q[i] <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= wr_entry_i.valid;
            cnt_q[wr_idx_i]   <= wr_entry_i.cnt;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]    <= wr_entry_i.tag;
            target_q[wr_idx_i] <= wr_entry_i.target;
        end
    end
    assign rd_if_o = {valid_q[rd_if_idx_i], tag_q[rd_if_idx_i], target_q[rd_if_idx_i], cnt_q[rd_if_idx_i]};
    assign rd_ex_o = {valid_q[rd_ex_idx_i], tag_q[rd_ex_idx_i], target_q[rd_ex_idx_i], cnt_q[rd_ex_idx_i]};
endmodule

// File: rtl/btb_2way_bht.sv
// btb_2way_bht: 2-way set-associative BTB with saturating direction counters, LRU and prediction stats
module btb_2way_bht import btb_pkg::*; #(
    parameter int SET_ADDR_LEN = 6,
    parameter int CNT_W        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PC_origin_IF,
    output logic [31:0] PC_pred_IF,
    output logic        PC_pred_en_IF,
    output logic        hit_IF,
    input  logic        upd_en_EX,
    input  logic [31:0] PC_origin_EX,
    input  logic [31:0] PC_target_EX,
    input  logic        br_EX,
    input  logic        PC_pred_en_EX,
    input  logic [31:0] PC_pred_EX,
    output logic        mispred_EX,
    output logic [31:0] pred_right_cnt,
    output logic [31:0] pred_wrong_cnt
);
    localparam int SETS = 1 << SET_ADDR_LEN;
    logic [SET_ADDR_LEN-1:0] idx_if, idx_ex;
    logic [TAG_MW-1:0]       tag_if, tag_ex;
    btb_entry_t              rd_if [2];
    btb_entry_t              rd_ex [2];
    btb_entry_t              sel_if, sel_ex, wr_entry;
    logic [1:0]              hit_if, hit_ex, wr_en;
    logic                    way;
    logic [SETS-1:0]         lru_q, lru_d;
    logic [31:0]             right_q, right_d, wrong_q, wrong_d;
    logic                    unused;
    assign idx_if = PC_origin_IF[SET_ADDR_LEN+1:2];
    assign idx_ex = PC_origin_EX[SET_ADDR_LEN+1:2];
    assign tag_if = TAG_MW'(PC_origin_IF[31:SET_ADDR_LEN+2]);
    assign tag_ex = TAG_MW'(PC_origin_EX[31:SET_ADDR_LEN+2]);
    assign unused = ^{PC_origin_IF[1:0], PC_origin_EX[1:0], sel_if.cnt};
    for (genvar w = 0; w < 2; w++) begin : g_way
        btb_set_ram #(.SET_ADDR_LEN(SET_ADDR_LEN)) u_ram (
            .clk         (clk),
            .rst_n       (rst_n),
            .rd_if_idx_i (idx_if),
            .rd_ex_idx_i (idx_ex),
            .wr_en_i     (wr_en[w]),
            .wr_idx_i    (idx_ex),
            .wr_entry_i  (wr_entry),
            .rd_if_o     (rd_if[w]),
            .rd_ex_o     (rd_ex[w])
        );
        assign hit_if[w] = rd_if[w].valid & (rd_if[w].tag == tag_if);
        assign hit_ex[w] = rd_ex[w].valid & (rd_ex[w].tag == tag_ex);
        assign wr_en[w]  = upd_en_EX & ((|hit_ex) | br_EX) & (way == 1'(w));
    end
    assign hit_IF        = |hit_if;
    assign sel_if        = hit_if[0] ? rd_if[0] : rd_if[1];
    assign PC_pred_IF    = hit_IF ? sel_if.target : '0;
    assign PC_pred_en_IF = hit_IF & sel_if.cnt[CNT_W-1];
    assign mispred_EX    = upd_en_EX & ((br_EX != PC_pred_en_EX) | (br_EX & PC_pred_en_EX & (PC_pred_EX != PC_target_EX)));
    // Hit way first, then an empty way (way0 preferred), else the LRU victim.
    always_comb begin
        way             = hit_ex[0] ? 1'b0 : hit_ex[1] ? 1'b1 :
                          !rd_ex[0].valid ? 1'b0 : !rd_ex[1].valid ? 1'b1 : lru_q[idx_ex];
        sel_ex          = rd_ex[way];
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = tag_ex;
        wr_entry.target = br_EX ? PC_target_EX : sel_ex.target;
        wr_entry.cnt    = (|hit_ex) ? sat_update(sel_ex.cnt, br_EX, CNT_W) : CNT_MW'(1 << (CNT_W - 1));
        lru_d           = lru_q;
        if (|wr_en) lru_d[idx_ex] = ~way;
        right_d         = (upd_en_EX & !mispred_EX & ~&right_q) ? right_q + 32'd1 : right_q;
        wrong_d         = (upd_en_EX & mispred_EX & ~&wrong_q) ? wrong_q + 32'd1 : wrong_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lru_q   <= '0;
            right_q <= '0;
            wrong_q <= '0;
        end else begin
            lru_q   <= lru_d;
            right_q <= right_d;
            wrong_q <= wrong_d;
        end
    end
    assign pred_right_cnt = right_q;
    assign pred_wrong_cnt = wrong_q;
endmodule

// File: tb/tb_btb_2way_bht.sv
// tb_btb_2way_bht: table-driven directed checks of lookup, update, LRU eviction, stats and async reset
module tb_btb_2way_bht;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] PC_origin_IF = '0, PC_pred_IF, PC_origin_EX = '0, PC_target_EX = '0, PC_pred_EX = '0;
    logic        PC_pred_en_IF, hit_IF, upd_en_EX = 1'b0, br_EX = 1'b0, PC_pred_en_EX = 1'b0, mispred_EX;
    logic [31:0] pred_right_cnt, pred_wrong_cnt;
    typedef struct {
        logic        upd;
        logic [31:0] pc_ex, tgt;
        logic        br, pen;
        logic [31:0] ppred, pc_if;
        logic        e_hit, e_en;
        logic [31:0] e_pred;
        logic        e_mis;
    } vec_t;
    vec_t        tab[$];
    int          checks = 0, errors = 0, split;
    logic [31:0] m_right = '0, m_wrong = '0;
    btb_2way_bht #(.SET_ADDR_LEN(6), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .PC_origin_IF(PC_origin_IF), .PC_pred_IF(PC_pred_IF),
        .PC_pred_en_IF(PC_pred_en_IF), .hit_IF(hit_IF), .upd_en_EX(upd_en_EX),
        .PC_origin_EX(PC_origin_EX), .PC_target_EX(PC_target_EX), .br_EX(br_EX),
        .PC_pred_en_EX(PC_pred_en_EX), .PC_pred_EX(PC_pred_EX), .mispred_EX(mispred_EX),
        .pred_right_cnt(pred_right_cnt), .pred_wrong_cnt(pred_wrong_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask
    function automatic void add(input logic upd, input logic [31:0] pc_ex, input logic [31:0] tgt,
                                input logic br, input logic pen, input logic [31:0] ppred,
                                input logic [31:0] pc_if, input logic e_hit, input logic e_en,
                                input logic [31:0] e_pred, input logic e_mis);
        vec_t v;
        v = '{upd, pc_ex, tgt, br, pen, ppred, pc_if, e_hit, e_en, e_pred, e_mis};
        tab.push_back(v);
    endfunction
    task automatic apply(input vec_t v, input int i);
        @(negedge clk);
        upd_en_EX = v.upd; PC_origin_EX = v.pc_ex; PC_target_EX = v.tgt; br_EX = v.br;
        PC_pred_en_EX = v.pen; PC_pred_EX = v.ppred; PC_origin_IF = v.pc_if;
        #2;
        chk($sformatf("v%0d hit", i), 32'(hit_IF), 32'(v.e_hit));
        chk($sformatf("v%0d en", i), 32'(PC_pred_en_IF), 32'(v.e_en));
        chk($sformatf("v%0d pred", i), PC_pred_IF, v.e_pred);
        chk($sformatf("v%0d mispred", i), 32'(mispred_EX), 32'(v.e_mis));
        chk($sformatf("v%0d right", i), pred_right_cnt, m_right);
        chk($sformatf("v%0d wrong", i), pred_wrong_cnt, m_wrong);
        if (v.upd) begin
            if (v.e_mis) m_wrong++;
            else m_right++;
        end
    endtask
    initial begin
        // upd, pc_ex, tgt, br, pen, ppred, pc_if | hit, en, pred, mis
        add(0, 'h0000, 'h0000, 0, 0, 'h0000, 'h1000, 0, 0, 'h0000, 0);
        add(1, 'h1000, 'h1080, 1, 0, 'h0000, 'h1000, 0, 0, 'h0000, 1);
        add(0, 'h0000, 'h0000, 0, 0, 'h0000, 'h1000, 1, 1, 'h1080, 0);
        add(1, 'h1000, 'h1080, 0, 1, 'h1080, 'h1000, 1, 1, 'h1080, 1);
        add(0, 'h0000, 'h0000, 0, 0, 'h0000, 'h1000, 1, 0, 'h1080, 0);
        add(1, 'h1000, 'h1080, 0, 0, 'h0000, 'h1000, 1, 0, 'h1080, 0);
        add(1, 'h1000, 'h1080, 0, 0, 'h0000, 'h1000, 1, 0, 'h1080, 0);
        add(0, 'h0000, 'h0000, 0, 0, 'h0000, 'h1000, 1, 0, 'h1080, 0);
        add(1, 'h1000, 'h1080, 1, 0, 'h0000, 'h1000, 1, 0, 'h1080, 1);
        add(1, 'h1000, 'h1080, 1, 1, 'h1080, 'h1000, 1, 0, 'h1080, 0);
        add(1, 'h1000, 'h1080, 1, 1, 'h1080, 'h1000, 1, 1, 'h1080, 0);
        add(1, 'h1000, 'h1080, 1, 1, 'h1080, 'h1000, 1, 1, 'h1080, 0);
        add(0, 'h0000, 'h0000, 0, 0, 'h0000, 'h1000, 1, 1, 'h1080, 0);
        add(1, 'h1000, 'h1080, 0, 1, 'h1080, 'h1002, 1, 1, 'h1080, 1);
        add(1, 'h3004, 'h2000, 1, 0, 'h0000, 'h3004, 0, 0, 'h0000, 1);
        add(1, 'h3004, 'h2040, 1, 1, 'h2000, 'h3004, 1, 1, 'h2000, 1);
        add(1, 'h3004, 'h2040, 1, 1, 'h2040, 'h3004, 1, 1, 'h2040, 0);
        add(1, 'h5008, 'h9000, 0, 0, 'h0000, 'h5008, 0, 0, 'h0000, 0);
        add(0, 'h5008, 'h9000, 1, 0, 'h0000, 'h5008, 0, 0, 'h0000, 0);
        add(0, 'h0000, 'h0000, 0, 0, 'h0000, 'h5008, 0, 0, 'h0000, 0);
        add(0, 'h0000, 'h0000, 0, 0, 'h0000, 'h1000, 1, 1, 'h1080, 0);
        split = tab.size();
        add(1, 'h0000, 'h0100, 1, 0, 'h0000, 'h0000, 0, 0, 'h0000, 1);
        add(1, 'h0100, 'h0200, 1, 0, 'h0000, 'h0100, 0, 0, 'h0000, 1);
        add(1, 'h0200, 'h0300, 1, 0, 'h0000, 'h0200, 0, 0, 'h0000, 1);
        add(0, 'h0000, 'h0000, 0, 0, 'h0000, 'h0100, 1, 1, 'h0200, 0);
        add(0, 'h0000, 'h0000, 0, 0, 'h0000, 'h0200, 1, 1, 'h0300, 0);
        add(0, 'h0000, 'h0000, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 0);
        add(1, 'h0100, 'h0200, 0, 1, 'h0200, 'h0100, 1, 1, 'h0200, 1);
        add(1, 'h0300, 'h0400, 1, 0, 'h0000, 'h0300, 0, 0, 'h0000, 1);
        add(0, 'h0000, 'h0000, 0, 0, 'h0000, 'h0100, 1, 0, 'h0200, 0);
        add(0, 'h0000, 'h0000, 0, 0, 'h0000, 'h0200, 0, 0, 'h0000, 0);
        add(0, 'h0000, 'h0000, 0, 0, 'h0000, 'h0300, 1, 1, 'h0400, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < split; i++) apply(tab[i], i);
        // Async reset mid-cycle while an update is pending: outputs clear at once, the update is lost.
        @(negedge clk);
        upd_en_EX = 1'b0; PC_origin_IF = 'h1000;
        #2;
        chk("pre-reset hit", 32'(hit_IF), 32'd1);
        #1;
        rst_n = 1'b0; upd_en_EX = 1'b1; PC_origin_EX = 'h7000; PC_target_EX = 'h7777;
        br_EX = 1'b1; PC_pred_en_EX = 1'b0;
        #1;
        chk("reset hit", 32'(hit_IF), 32'd0);
        chk("reset en", 32'(PC_pred_en_IF), 32'd0);
        chk("reset pred", PC_pred_IF, 32'd0);
        chk("reset right", pred_right_cnt, 32'd0);
        chk("reset wrong", pred_wrong_cnt, 32'd0);
        @(negedge clk);
        upd_en_EX = 1'b0; rst_n = 1'b1; PC_origin_IF = 'h7000;
        #2;
        chk("discarded update hit", 32'(hit_IF), 32'd0);
        PC_origin_IF = 'h1000;
        #1;
        chk("post-reset hit", 32'(hit_IF), 32'd0);
        m_right = '0; m_wrong = '0;
        for (int i = split; i < tab.size(); i++) apply(tab[i], i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
